// File: rtl/pci_slave_if.sv
// Target-side PCI control bundle: command/byte enables, framing and handshakes.
// AD is a shared tristate bus and stays a plain inout port on the target.
interface pci_slave_if;
   logic [3:0] CBE;
   logic       FRAME;
   logic       IRDY;
   logic       TRDY;
   logic       DEVSEL;

   modport slave  (input CBE, FRAME, IRDY, output TRDY, DEVSEL);
   modport master (output CBE, FRAME, IRDY, input TRDY, DEVSEL);
endinterface

// File: rtl/pci_slave.sv
// 32-bit PCI I/O target with a DEPTH-word register file, single and burst phases.
// Define MEM_CMD_EN to also claim memory read (0110) and memory write (0111).
module pci_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_C9C0,
   parameter int          DEPTH     = 16
) (
   input  logic        CLK,
   input  logic        RST,
   inout  wire  [31:0] AD,
   pci_slave_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, TURN, WDATA, RDATA, DONE} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   ad_q;
   logic          ad_oe;
   logic          trdy_q;
   logic          devsel_q;
   logic          frame_prev;

   logic          hit;
   logic          cmd_rd;
   logic          cmd_wr;
   logic          addr_phase;
   logic          release_now;
   logic [IW-1:0] idx_inc;
   wire           unused_ad = ^AD[1:0];

   always_comb begin
      cmd_rd = (bus.CBE == 4'b0010);
      cmd_wr = (bus.CBE == 4'b0011);
`ifdef MEM_CMD_EN
      cmd_rd = cmd_rd | (bus.CBE == 4'b0110);
      cmd_wr = cmd_wr | (bus.CBE == 4'b0111);
`else
      cmd_rd = cmd_rd & 1'b1;
      cmd_wr = cmd_wr & 1'b1;
`endif
   end

   assign hit        = (AD[31:6] == BASE_ADDR[31:6]);
   assign addr_phase = !bus.FRAME && frame_prev;
   assign idx_inc    = idx + 1'b1;

   // Last phase (FRAME high on a transfer) or master abort (FRAME and IRDY both high).
   always_comb begin
      release_now = 1'b0;
      case (state)
         TURN:         release_now = bus.FRAME && bus.IRDY;
         WDATA, RDATA: release_now = bus.FRAME;
         default:      release_now = 1'b0;
      endcase
   end

   assign AD         = ad_oe ? ad_q : 32'bz;
   assign bus.TRDY   = trdy_q;
   assign bus.DEVSEL = devsel_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         idx        <= '0;
         ad_q       <= '0;
         ad_oe      <= 1'b0;
         trdy_q     <= 1'b1;
         devsel_q   <= 1'b1;
         frame_prev <= 1'b1;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         frame_prev <= bus.FRAME;
         case (state)
            IDLE: begin
               if (addr_phase) begin
                  idx <= AD[2 +: IW];
                  if (hit && cmd_wr) begin
                     devsel_q <= 1'b0;
                     trdy_q   <= 1'b0;
                     state    <= WDATA;
                  end else if (hit && cmd_rd) begin
                     devsel_q <= 1'b0;
                     state    <= TURN;
                  end
               end
            end
            TURN: begin
               ad_q   <= mem[idx];
               ad_oe  <= 1'b1;
               trdy_q <= 1'b0;
               state  <= RDATA;
            end
            WDATA: begin
               if (!bus.IRDY) begin
                  for (int n = 0; n < 4; n++)
                     if (!bus.CBE[n]) mem[idx][8*n +: 8] <= AD[8*n +: 8];
                  idx <= idx_inc;
               end
            end
            RDATA: begin
               if (!bus.IRDY) begin
                  ad_q <= mem[idx_inc];
                  idx  <= idx_inc;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         // Releasing overrides whatever the state arm scheduled for the outputs.
         if (release_now) begin
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            ad_oe    <= 1'b0;
            state    <= DONE;
         end
      end
   end
endmodule

// File: tb/tb_pci_slave.sv
// Self-checking bench for pci_slave: a master model drives transactions, a shadow
// memory predicts read data, and a queue scoreboard checks every read transfer.
module tb_pci_slave;
   logic        CLK = 1'b0;
   logic        RST;
   wire  [31:0] AD;
   logic [31:0] tb_ad;
   logic        tb_oe;

   pci_slave_if bus ();

   pci_slave #(.BASE_ADDR(32'h0000_C9C0), .DEPTH(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .AD  (AD),
      .bus (bus)
   );

   assign AD = tb_oe ? tb_ad : 32'bz;

   always #5 CLK = ~CLK;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] model [16];
   logic [31:0] exp_q [$];
   logic        reading = 1'b0;
   logic [31:0] wd  [4];
   logic [3:0]  wbe [4];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, act, exp);
   endtask

   // Scoreboard: every read transfer seen on the bus pops one predicted word.
   always @(negedge CLK) begin
      if (reading && bus.TRDY === 1'b0 && bus.IRDY === 1'b0) begin
         if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else check("rdata", AD, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_bus();
      bus.FRAME = 1'b1;
      bus.IRDY  = 1'b1;
      bus.CBE   = 4'b0000;
      tb_oe     = 1'b0;
      tick();
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0] cmd, input int n, input int waits);
      logic [3:0] i;
      i = addr[5:2];
      bus.FRAME = 1'b0; bus.IRDY = 1'b1; bus.CBE = cmd; tb_oe = 1'b1; tb_ad = addr;
      tick();
      check("wr_devsel", 32'(bus.DEVSEL), 32'd0);
      check("wr_trdy", 32'(bus.TRDY), 32'd0);
      for (int b = 0; b < n; b++) begin
         if (b == 0) begin
            for (int w = 0; w < waits; w++) begin
               tb_ad = 32'hDEAD_BEEF; bus.CBE = 4'b0000; bus.IRDY = 1'b1; bus.FRAME = 1'b0;
               tick();
               check("wait_trdy", 32'(bus.TRDY), 32'd0);
            end
         end
         tb_ad = wd[b]; bus.CBE = wbe[b]; bus.IRDY = 1'b0; bus.FRAME = (b == n - 1);
         tick();
         for (int k = 0; k < 4; k++)
            if (!wbe[b][k]) model[i][8*k +: 8] = wd[b][8*k +: 8];
         i = i + 4'd1;
      end
      check("wr_end_trdy", 32'(bus.TRDY), 32'd1);
      check("wr_end_devsel", 32'(bus.DEVSEL), 32'd1);
      idle_bus();
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0] cmd, input int n, input bit claimed);
      logic [3:0] i;
      i = addr[5:2];
      bus.FRAME = 1'b0; bus.IRDY = 1'b1; bus.CBE = cmd; tb_oe = 1'b1; tb_ad = addr;
      tick();
      tb_oe = 1'b0; bus.IRDY = 1'b0; bus.FRAME = (n == 1); bus.CBE = 4'b0000;
      reading = 1'b1;
      if (claimed) begin
         for (int j = 0; j < n; j++) begin
            exp_q.push_back(model[i]);
            i = i + 4'd1;
         end
         check("rd_devsel", 32'(bus.DEVSEL), 32'd0);
         check("rd_turn_trdy", 32'(bus.TRDY), 32'd1);
         tick();
         check("rd_trdy", 32'(bus.TRDY), 32'd0);
         check("rd_oe", 32'(dut.ad_oe), 32'd1);
         for (int j = 0; j < n; j++) begin
            bus.FRAME = (j == n - 1);
            tick();
         end
         check("rd_end_trdy", 32'(bus.TRDY), 32'd1);
         check("rd_end_devsel", 32'(bus.DEVSEL), 32'd1);
         check("rd_end_oe", 32'(dut.ad_oe), 32'd0);
         check("sb_empty", 32'(exp_q.size()), 32'd0);
      end else begin
         check("nc_devsel0", 32'(bus.DEVSEL), 32'd1);
         for (int j = 0; j < 2; j++) begin
            tick();
            check("nc_devsel", 32'(bus.DEVSEL), 32'd1);
            check("nc_oe", 32'(dut.ad_oe), 32'd0);
         end
      end
      reading = 1'b0;
      idle_bus();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; bus.FRAME = 1'b1; bus.IRDY = 1'b1; bus.CBE = 4'b0000;
      tb_oe = 1'b0; tb_ad = '0;
      for (int k = 0; k < 16; k++) model[k] = '0;
      tick();
      check("rst_trdy", 32'(bus.TRDY), 32'd1);
      check("rst_devsel", 32'(bus.DEVSEL), 32'd1);
      check("rst_oe", 32'(dut.ad_oe), 32'd0);
      RST = 1'b0;
      tick();
      do_read(32'h0000_C9C4, 4'b0010, 1, 1'b1);

      wd[0] = 32'h9999_9999; wbe[0] = 4'b1101;
      do_write(32'h0000_C9C7, 4'b0011, 1, 0);
      do_read(32'h0000_C9C5, 4'b0010, 1, 1'b1);

      wd[0] = 32'h1234_5678; wbe[0] = 4'b0000;
      do_write(32'h0000_C9C8, 4'b0011, 1, 3);
      do_read(32'h0000_C9C8, 4'b0010, 1, 1'b1);

      wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
      wbe[0] = 4'b0000; wbe[1] = 4'b0000; wbe[2] = 4'b0000;
      do_write(32'h0000_C9FC, 4'b0011, 3, 0);
      do_read(32'h0000_C9FC, 4'b0010, 3, 1'b1);

      wd[0] = 32'hAAAA_5555; wbe[0] = 4'b1111;
      do_write(32'h0000_C9C4, 4'b0011, 1, 0);
      do_read(32'h0000_C9C4, 4'b0010, 1, 1'b1);

      bus.FRAME = 1'b0; bus.IRDY = 1'b1; bus.CBE = 4'b0011; tb_oe = 1'b1; tb_ad = 32'h0000_1000;
      tick();
      check("miss_devsel", 32'(bus.DEVSEL), 32'd1);
      tb_ad = 32'hFFFF_FFFF; bus.CBE = 4'b0000; bus.IRDY = 1'b0; bus.FRAME = 1'b1;
      tick();
      check("miss_trdy", 32'(bus.TRDY), 32'd1);
      idle_bus();
      do_read(32'h0000_C9C0, 4'b0010, 1, 1'b1);
      do_read(32'h0000_1000, 4'b0010, 1, 1'b0);
`ifdef MEM_CMD_EN
      do_read(32'h0000_C9C0, 4'b0110, 1, 1'b1);
`else
      do_read(32'h0000_C9C0, 4'b0110, 1, 1'b0);
`endif

      bus.FRAME = 1'b0; bus.IRDY = 1'b1; bus.CBE = 4'b0011; tb_oe = 1'b1; tb_ad = 32'h0000_C9CC;
      tick();
      tb_ad = 32'h5A5A_5A5A; bus.CBE = 4'b0000; bus.IRDY = 1'b0; bus.FRAME = 1'b0; RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int k = 0; k < 16; k++) model[k] = '0;
      check("midrst_trdy", 32'(bus.TRDY), 32'd1);
      check("midrst_devsel", 32'(bus.DEVSEL), 32'd1);
      idle_bus();
      do_read(32'h0000_C9CC, 4'b0010, 1, 1'b1);
      do_read(32'h0000_C9FC, 4'b0010, 2, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pci_slave.md
Name: pci_slave

Overview:
- 32-bit PCI I/O target with a 16-word internal register file.
- Decodes the address phase on AD/CBE and claims hits by asserting DEVSEL.
- Completes single and burst data phases with the IRDY/TRDY handshake.
- Sits on the shared AD bus as a target alongside a PCI master; all bus control signals are active-low.

Parameters:
- BASE_ADDR, 32'h0000_C9C0, base of the claimed window; hit when AD[31:6] == BASE_ADDR[31:6].
- DEPTH, 16, number of 32-bit words; word index = AD[5:2].

Ports:
- CLK  input  1  single clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- AD  inout  32  multiplexed address/data; driven only during read data phases, else high-Z.
- CBE  input  4  command during address phase; active-low byte enables during data phases.
- FRAME  input  1  active-low, master transaction framing.
- IRDY  input  1  active-low, master data ready.
- TRDY  output  1  active-low, target data ready; registered.
- DEVSEL  output  1  active-low, device select; registered.

Behaviour:
- Reset (RST=1 at a rising edge):
  - TRDY=1, DEVSEL=1, AD high-Z, FSM to IDLE.
  - All memory words cleared to 0; burst index cleared.
  - Reset mid-transaction aborts immediately with no further writes.
- Supported commands: 4'b0010 I/O read, 4'b0011 I/O write. Other commands are never claimed (see optional feature).
- FSM states: IDLE, TURN, WDATA, RDATA, DONE.
- IDLE:
  - Address phase = edge where FRAME is sampled low and FRAME was high at the previous edge.
  - Latch the command and the index AD[5:2].
  - On hit with a supported command, DEVSEL goes low after this edge (fast decode).
  - Write: TRDY also goes low, next state WDATA.
  - Read: TRDY stays high, next state TURN.
  - Miss or unsupported command: stay IDLE, outputs idle until FRAME returns high.
- TURN: one turnaround cycle. After the edge, drive AD=mem[idx], TRDY low, go RDATA.
- Transfer: occurs at a rising edge with IRDY=0 and TRDY=0. With IRDY=1 the target waits, holding TRDY low and AD stable.
- WDATA transfer:
  - For each n where CBE[n]==0, mem[idx][8n+7:8n] <= AD[8n+7:8n]; other bytes are unchanged.
  - CBE=4'b1111 writes nothing but still counts as a transfer.
- RDATA transfer: AD updates to mem[idx+1] for the next phase. Byte enables are ignored on reads.
- After every transfer, idx increments mod DEPTH (15 wraps to 0).
- Last phase: a transfer with FRAME=1 sampled. After that edge, TRDY=1 and DEVSEL=1, AD to high-Z, go DONE. DONE returns to IDLE next cycle.
- Master abort: FRAME=1 and IRDY=1 while in WDATA/RDATA/TURN releases outputs as for the last phase, with no transfer.
- A new address phase is accepted only from IDLE.
- Write earliest timing: address at edge k, first write at edge k+1.
- Read earliest timing: address at edge k, data on AD after edge k+1, first transfer at edge k+2.

Optional Feature:
- Macro MEM_CMD_EN.
- Defined: also claims 4'b0110 (memory read) and 4'b0111 (memory write), with read and write timing identical to the I/O commands.
- Undefined: 0110/0111 are treated as unsupported and never claimed.

Test Plan:
- Reset: RST=1 for one edge → TRDY=1, DEVSEL=1, AD=Z, mem[1]=0.
- Single write:
  - Address 32'h0000_C9C7, CBE=0011; then IRDY=0, AD=32'h9999_9999, CBE=1101, FRAME=1.
  - → DEVSEL/TRDY low the cycle after address; mem[1]=32'h0000_9900; both high after transfer.
- Read back: address 32'h0000_C9C5, CBE=0010, IRDY=0, FRAME=1 on the data phase → one turnaround, then AD=32'h0000_9900 with TRDY=0.
- Wait states: write with IRDY=1 for 3 cycles → no memory change; TRDY held low; transfer on the first edge with IRDY=0.
- Burst wrap:
  - Write address 32'h0000_C9FC, data 1, 2, 3 with CBE=0000.
  - → mem[15]=1, mem[0]=2, mem[1]=3; a read burst returns 1, 2, 3.
- Miss/unsupported: address 32'h0000_1000 CBE=0011, or 32'h0000_C9C0 CBE=0110 without MEM_CMD_EN → DEVSEL stays 1, AD never driven, memory unchanged; with MEM_CMD_EN the 0110 read is claimed.
